// File: rtl/rsa_operand_loader_pkg.sv
// Shared rsa4k parameters and the operand loader's state encoding.
// Operand width, stream word width and words per operand live here.
package rsa_operand_loader_pkg;

  localparam int RSA4K_WIDTH = 4096;
  localparam int RSA4K_WORD  = 32;
  localparam int RSA4K_NW    = RSA4K_WIDTH / RSA4K_WORD;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4
  } ldr_state_t;

  // Counter width for a word index.
  // It is never narrower than one bit, so NW == 1 still yields a legal vector.
  function automatic int idx_w(input int nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

endpackage

// File: rtl/rsa_word_serializer.sv
// Holds the rsa4k result and streams it out one word at a time, least-significant word first.
// It uses a valid/ready handshake toward the sink.
module rsa_word_serializer
  import rsa_operand_loader_pkg::*;
#(
  parameter int WIDTH = RSA4K_WIDTH,
  parameter int WORD  = RSA4K_WORD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             out_ready,
  output logic [WORD-1:0]  out_data,
  output logic             out_valid,
  output logic             last_xfer
);

  localparam int NW = WIDTH / WORD;
  localparam int CW = idx_w(NW);

  logic [NW-1:0][WORD-1:0] res_q;
  logic [CW-1:0]           j_q;
  logic                    vld_q;
  logic                    xfer;

  assign xfer      = vld_q & out_ready;
  assign last_xfer = xfer && (j_q == CW'(NW - 1));
  assign out_valid = vld_q;
  assign out_data  = res_q[j_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= '0;
      j_q   <= '0;
      vld_q <= 1'b0;
    end else if (load) begin
      res_q <= din;
      j_q   <= '0;
      vld_q <= 1'b1;
    end else if (xfer) begin
      if (last_xfer) begin
        j_q   <= '0;
        vld_q <= 1'b0;
      end else begin
        j_q   <= j_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rsa_operand_loader.sv
// Streams message/exponent/modulus into wide operand registers, launches rsa4k,
// and serializes the captured result back out as a word stream.
module rsa_operand_loader
  import rsa_operand_loader_pkg::*;
#(
  parameter int WIDTH = RSA4K_WIDTH,
  parameter int WORD  = RSA4K_WORD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WORD-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WORD-1:0]  out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] message,
  output logic [WIDTH-1:0] exponent,
  output logic [WIDTH-1:0] modulus,
  output logic             go,
  input  logic             done,
  input  logic [WIDTH-1:0] cypher,
  output logic             busy,
  output logic             err
);

  localparam int NW = WIDTH / WORD;
  localparam int CW = idx_w(NW);

  ldr_state_t state_q, state_d;

  logic [1:0]              op_q;
  logic [CW-1:0]           cnt_q;
  logic [NW-1:0][WORD-1:0] msg_q, exp_q, mod_q;
  logic                    accept, last_word, op_last, capture, ser_last;

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign accept    = in_valid & in_ready;
  assign op_last   = (cnt_q == CW'(NW - 1));
  assign last_word = op_last && (op_q == 2'd2);

  assign message  = msg_q;
  assign exponent = exp_q;
  assign modulus  = mod_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    err     = 1'b0;
    capture = 1'b0;
    busy    = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_LOAD;
      ST_LOAD:  if (accept && last_word) state_d = ST_CHECK;
      ST_CHECK: begin
        // An even modulus cannot be used by the Montgomery core; reject the job.
        if (!mod_q[0][0]) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        go = 1'b1;
        if (done) begin
          capture = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (ser_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The operand index steps past modulus on the last word, so CHECK rewinds it.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= '0;
      cnt_q <= '0;
      msg_q <= '0;
      exp_q <= '0;
      mod_q <= '0;
    end else begin
      if (state_q == ST_CHECK) begin
        op_q  <= '0;
        cnt_q <= '0;
      end else if (accept) begin
        case (op_q)
          2'd0:    msg_q[cnt_q] <= in_data;
          2'd1:    exp_q[cnt_q] <= in_data;
          2'd2:    mod_q[cnt_q] <= in_data;
          default: ;
        endcase
        if (op_last) begin
          cnt_q <= '0;
          op_q  <= op_q + 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  rsa_word_serializer #(
    .WIDTH (WIDTH),
    .WORD  (WORD)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (capture),
    .din       (cypher),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .last_xfer (ser_last)
  );

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Directed bench for rsa_operand_loader; the bench plays the rsa4k core
// by answering go with a hand-computed cypher value.
module tb_rsa_operand_loader;
  import rsa_operand_loader_pkg::*;

  localparam int WIDTH = 4096;
  localparam int WORD  = 32;
  localparam int NW    = WIDTH / WORD;

  typedef logic [WIDTH-1:0] wide_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [WORD-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WORD-1:0]  out_data;
  logic             out_valid;
  logic             out_ready;
  wide_t            message, exponent, modulus, cypher;
  logic             go, done, busy, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rsa_operand_loader #(.WIDTH(WIDTH), .WORD(WORD)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .message(message), .exponent(exponent), .modulus(modulus),
    .go(go), .done(done), .cypher(cypher), .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chkw(input string tag, input wide_t got, input wide_t exp);
    int k;
    checks++;
    assert (got === exp) else begin
      errors++;
      k = 0;
      for (int i = NW - 1; i >= 0; i--)
        if (got[i*WORD +: WORD] !== exp[i*WORD +: WORD]) k = i;
      $error("FAIL %s: word %0d got %h expected %h", tag, k,
             got[k*WORD +: WORD], exp[k*WORD +: WORD]);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input logic [WORD-1:0] w, input bit gaps);
    int n;
    if (gaps)
      while ($urandom_range(1, 0) == 1) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("in_ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_words(input wide_t m, input wide_t e, input wide_t p,
                            input int nwords, input bit gaps);
    wide_t ops [3];
    int cnt;
    ops[0] = m; ops[1] = e; ops[2] = p;
    cnt = 0;
    for (int op = 0; op < 3; op++)
      for (int k = 0; k < NW; k++) begin
        if (cnt < nwords) send_word(ops[op][k*WORD +: WORD], gaps);
        cnt++;
      end
  endtask

  // Full load followed by the exact go-latency checks; ends with go high.
  task automatic load_and_launch(input wide_t m, input wide_t e, input wide_t p,
                                 input bit gaps, input string tag);
    load_words(m, e, p, 3 * NW, gaps);
    chk({tag, "_check_go"}, go, 0);
    chk({tag, "_check_busy"}, busy, 1);
    chk({tag, "_check_inrdy"}, in_ready, 0);
    chk({tag, "_check_err"}, err, 0);
    @(negedge clk);
    chk({tag, "_go_rise"}, go, 1);
    chkw({tag, "_message"}, message, m);
    chkw({tag, "_exponent"}, exponent, e);
    chkw({tag, "_modulus"}, modulus, p);
    repeat (3) @(negedge clk);
    chk({tag, "_go_held"}, go, 1);
    chk({tag, "_run_inrdy"}, in_ready, 0);
  endtask

  task automatic finish_done(input wide_t cy, input string tag);
    done   = 1'b1;
    cypher = cy;
    @(negedge clk);
    done = 1'b0;
    chk({tag, "_go_drop"}, go, 0);
    chk({tag, "_ov_rise"}, out_valid, 1);
  endtask

  task automatic drain(input wide_t exp, input bit stalls, input string tag);
    logic [WORD-1:0] held;
    for (int j = 0; j < NW; j++) begin
      if (stalls)
        while ($urandom_range(1, 0) == 1) begin
          out_ready = 1'b0;
          held = out_data;
          @(negedge clk);
          chk($sformatf("%s_stall%0d", tag, j), out_data, held);
          chk($sformatf("%s_stallv%0d", tag, j), out_valid, 1);
        end
      if (j == 0) chk({tag, "_drain_inrdy"}, in_ready, 0);
      out_ready = 1'b1;
      chk($sformatf("%s_v%0d", tag, j), out_valid, 1);
      chk($sformatf("%s_w%0d", tag, j), out_data, exp[j*WORD +: WORD]);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk({tag, "_ov_end"}, out_valid, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_inrdy_end"}, in_ready, 1);
  endtask

  initial begin
    wide_t pm, pe, pn, pc;
    for (int k = 0; k < NW; k++) begin
      pm[k*WORD +: WORD] = 32'h1000_0000 | k;
      pe[k*WORD +: WORD] = 32'h2000_0000 | k;
      pn[k*WORD +: WORD] = 32'h3000_0001 | (k << 4);
      pc[k*WORD +: WORD] = {k[7:0], ~k[7:0], 16'hA5C3};
    end

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    done = 1'b0; cypher = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_go", go, 0);
    chk("rst_err", err, 0);
    chk("rst_ov", out_valid, 0);
    chkw("rst_msg", message, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_inrdy", in_ready, 1);

    // 8^13 mod 77 = 50
    load_and_launch(wide_t'(8), wide_t'(13), wide_t'(77), 1'b0, "job1");
    finish_done(wide_t'(50), "job1");
    drain(wide_t'(50), 1'b0, "job1");
    chk("idle_go", go, 0);

    // 50^37 mod 77 = 8
    load_and_launch(wide_t'(50), wide_t'(37), wide_t'(77), 1'b0, "job2");
    finish_done(wide_t'(8), "job2");
    drain(wide_t'(8), 1'b0, "job2");

    // Even modulus is rejected in CHECK.
    load_words(wide_t'(8), wide_t'(13), wide_t'(76), 3 * NW, 1'b0);
    chk("even_err", err, 1);
    chk("even_go", go, 0);
    chk("even_busy", busy, 1);
    @(negedge clk);
    chk("even_err_drop", err, 0);
    chk("even_busy_drop", busy, 0);
    chk("even_inrdy", in_ready, 1);
    repeat (3) @(negedge clk);
    chk("even_go_never", go, 0);

    // Random input gaps and output stalls.
    load_and_launch(wide_t'(8), wide_t'(13), wide_t'(77), 1'b1, "gaps");
    finish_done(wide_t'(50), "gaps");
    drain(wide_t'(50), 1'b1, "gaps");

    // Reset partway through LOAD discards the partial job.
    load_words(wide_t'(8), wide_t'(13), wide_t'(77), 200, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chkw("midload_msg", message, '0);
    chkw("midload_exp", exponent, '0);
    chk("midload_busy", busy, 0);
    load_and_launch(wide_t'(8), wide_t'(13), wide_t'(77), 1'b0, "after_rst");
    finish_done(wide_t'(50), "after_rst");
    drain(wide_t'(50), 1'b0, "after_rst");

    // Reset during RUN, then a spurious done.
    load_and_launch(wide_t'(8), wide_t'(13), wide_t'(77), 1'b0, "runrst");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("runrst_go", go, 0);
    chk("runrst_busy", busy, 0);
    chkw("runrst_mod", modulus, '0);
    done = 1'b1; cypher = wide_t'(50);
    @(negedge clk);
    done = 1'b0;
    chk("spurious_ov", out_valid, 0);
    chk("spurious_busy", busy, 0);
    @(negedge clk);
    chk("spurious_ov2", out_valid, 0);

    // done held for three cycles; cypher changes after the first capture.
    load_and_launch(pm, pe, pn, 1'b0, "hold");
    done = 1'b1; cypher = pc;
    @(negedge clk);
    cypher = ~pc;
    chk("hold_go1", go, 0);
    chk("hold_ov1", out_valid, 1);
    chk("hold_w0_1", out_data, pc[WORD-1:0]);
    @(negedge clk);
    chk("hold_go2", go, 0);
    chk("hold_w0_2", out_data, pc[WORD-1:0]);
    @(negedge clk);
    done = 1'b0;
    chk("hold_go3", go, 0);
    chk("hold_w0_3", out_data, pc[WORD-1:0]);
    drain(pc, 1'b0, "hold");
    @(negedge clk);
    chk("hold_no_extra", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_operand_loader.md
RSA_OPERAND_LOADER -- requirements
Module: rsa_operand_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 4096: operand and result width in bits.
REQ-002 SHALL have parameter WORD, default 32: stream word width; WIDTH/WORD (NW, 128 by default) SHALL be an integer.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  WORD  operand word stream.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader accepts word; transfer when in_valid and in_ready are both high.
REQ-008 out_data  output  WORD  result word stream.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  sink accepts; transfer when out_valid and out_ready are both high.
REQ-011 message, exponent, modulus  output  WIDTH each  operands to rsa4k.
REQ-012 go  output  1  start level to rsa4k.
REQ-013 done  input  1  completion from rsa4k.
REQ-014 cypher  input  WIDTH  result from rsa4k.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 err  output  1  one-cycle pulse on a rejected job.

Function
REQ-017 States SHALL be IDLE, LOAD, CHECK, RUN, DRAIN.
REQ-018 IDLE: in_ready=1; the first accepted word SHALL enter LOAD and count as word 0.
REQ-019 LOAD: 3*NW words total, order message, exponent, modulus; within each operand least-significant word first; word k of an operand SHALL be written to bits [k*WORD +: WORD].
REQ-020 A 2-bit operand index and a log2(NW)-bit word counter SHALL track position; the counter wraps to 0 and the index increments after word NW-1.
REQ-021 in_ready SHALL be 1 in IDLE and LOAD only; words presented in other states SHALL NOT be consumed.
REQ-022 After the last modulus word is accepted, the FSM SHALL enter CHECK on the next cycle.
REQ-023 CHECK (one cycle): if modulus[0]==0, pulse err for one cycle, hold go low, return to IDLE; otherwise enter RUN.
REQ-024 RUN: go SHALL be held high from RUN entry until the first cycle done is sampled high; on that edge go SHALL drop, cypher SHALL be captured into a WIDTH-bit result register, and the FSM SHALL enter DRAIN.
REQ-025 done asserted while not in RUN SHALL be ignored.
REQ-026 message, exponent, modulus SHALL be held stable from CHECK until DRAIN exits.
REQ-027 DRAIN: out_valid=1, out_data = result word j, least-significant word first, j=0..NW-1; j SHALL advance only on a transfer; out_data SHALL stay stable while out_valid and !out_ready.
REQ-028 After transfer of word NW-1, the FSM SHALL return to IDLE in the same edge; out_valid SHALL be 0 the following cycle.
REQ-029 A new job SHALL be accepted only from IDLE, so at most one job is in flight; no back-to-back overlap of DRAIN and LOAD.
REQ-030 Latency: go SHALL rise exactly 2 cycles after the edge accepting the last modulus word; out_valid SHALL rise 1 cycle after the edge sampling done high.

Reset
REQ-031 On reset: state=IDLE; counters 0; go=0; err=0; out_valid=0; busy=0; in_ready=1 from the first cycle after reset.
REQ-032 Operand and result registers SHALL reset to 0.
REQ-033 Reset in any state, including mid-LOAD, RUN with go high, or DRAIN with a stalled word, SHALL abandon the job; partial words SHALL NOT be retained.

Structure
REQ-034 WIDTH, WORD, NW and the state encoding SHALL live in the shared parameter package alongside the existing rsa4k parameters.
REQ-035 One sub-module is natural: rsa_word_serializer (result register plus word index plus out handshake), instantiated once.
REQ-036 The loader SHALL instantiate no arithmetic; it SHALL connect directly to rsa4k ports of the same names.

Verification
REQ-037 Load message=8, exponent=13, modulus=77 as 384 words with in_valid held high -> go high 2 cycles after last word; on done, out word0=0x32 (50), words 1..127=0, busy low after word 127.
REQ-038 Second job with message=50, exponent=37, modulus=77 -> out word0=0x8, rest 0; go low in IDLE between jobs.
REQ-039 Modulus=76 (even) -> err single-cycle pulse in CHECK, go never rises, FSM in IDLE, in_ready=1 next cycle.
REQ-040 Random in_valid gaps and out_ready stalls (~50%) on the 8/13/77 job -> identical output words, out_data stable throughout each stall.
REQ-041 Reset asserted after 200 words loaded, then a full 8/13/77 job -> result 50; reset asserted during RUN -> go=0 next cycle, later spurious done ignored.
REQ-042 done held high for 3 cycles -> exactly one capture, go low after the first, exactly 128 output words.
